// File: rtl/wdt_timeout_if.sv
// rtl/wdt_timeout_if.sv - watchdog register-wrapper to timeout-core link
//
// Purpose: groups the watchdog register outputs (enable, kick and threshold)
// with the core's return signals (timeout, kick acknowledge and count).
// The master side is the register wrapper. The slave side is the counting core.
//
// Signals:
//   WDEN      wrapper -> core  watchdog enable level
//   WDLIVE    wrapper -> core  kick request level, held until isCNTRST is seen
//   WTOCNT    wrapper -> core  timeout threshold in ticks
//   WTO       core -> wrapper  timeout interrupt level
//   isCNTRST  core -> wrapper  one-cycle kick acknowledge
//   CNT       core -> wrapper  current tick count for readback
//   WPRE      core -> wrapper  pre-timeout warning (only with WDT_PREWARN_EN)

interface wdt_timeout_if #(
    parameter int CNT_W = 32
) ();
    logic             WDEN;
    logic             WDLIVE;
    logic [CNT_W-1:0] WTOCNT;
    logic             WTO;
    logic             isCNTRST;
    logic [CNT_W-1:0] CNT;
`ifdef WDT_PREWARN_EN
    logic             WPRE;
`endif

    modport master (
        output WDEN, WDLIVE, WTOCNT,
        input  WTO, isCNTRST, CNT
`ifdef WDT_PREWARN_EN
        , input WPRE
`endif
    );

    modport slave (
        input  WDEN, WDLIVE, WTOCNT,
        output WTO, isCNTRST, CNT
`ifdef WDT_PREWARN_EN
        , output WPRE
`endif
    );
endinterface

// File: rtl/wdt_timeout_core.sv
// rtl/wdt_timeout_core.sv - watchdog tick counter and timeout interrupt core
//
// Purpose: counts prescaled ticks while the watchdog is enabled. It raises
// WTO once the count has reached WTOCNT on a tick, and acknowledges kicks so
// that the register wrapper can clear its kick request.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   wdt_timeout_if.slave (WDEN/WDLIVE/WTOCNT in, WTO/isCNTRST/CNT out)
//
// Optional feature: define WDT_PREWARN_EN to add the registered WPRE warning
// output. WPRE asserts once the count is within PREWARN_CNT ticks of WTOCNT.

module wdt_timeout_core #(
    parameter int PRESCALE    = 1,
    parameter int CNT_W       = 32,
    parameter int PREWARN_CNT = 16
) (
    input  logic            clk,
    input  logic            rst,
    wdt_timeout_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             wto_q, wto_d;
    logic             ack_q, ack_d;
`ifdef WDT_PREWARN_EN
    localparam logic [CNT_W-1:0] PREWARN_V = CNT_W'(PREWARN_CNT);
    logic             wpre_q, wpre_d;
`endif

    logic kick;
    logic tick;

    // While an acknowledge is on the wire, the wrapper has not yet dropped
    // WDLIVE, so the same request must not be counted twice.
    assign kick = bus.WDLIVE & ~ack_q;
    assign tick = (pre_q == PRE_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            wto_q   <= 1'b0;
            ack_q   <= 1'b0;
`ifdef WDT_PREWARN_EN
            wpre_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            wto_q   <= wto_d;
            ack_q   <= ack_d;
`ifdef WDT_PREWARN_EN
            wpre_q  <= wpre_d;
`endif
        end
    end

    // Next-state logic. In RUN the priority is disable, then kick, then tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                pre_d = '0;
                if (bus.WDEN) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.WDEN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pre_d   = '0;
                end else if (kick) begin
                    cnt_d = '0;
                    pre_d = '0;
                end else if (tick) begin
                    pre_d = '0;
                    // WTOCNT is compared live. A threshold lowered below the
                    // current count expires on the next tick. The count never
                    // passes the threshold, so it cannot wrap.
                    if (cnt_q >= bus.WTOCNT) begin
                        state_d = EXPIRED;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            EXPIRED: begin
                if (!bus.WDEN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pre_d   = '0;
                end else if (kick) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    pre_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pre_d   = '0;
            end
        endcase
    end

    // Output logic. This computes the values of the registered outputs.
    always_comb begin
        // A kick is acknowledged in every state, even when a disable wins.
        ack_d = kick;
        wto_d = (state_d == EXPIRED);
`ifdef WDT_PREWARN_EN
        wpre_d = (state_d == RUN) && !kick &&
                 (bus.WTOCNT >= PREWARN_V) &&
                 (cnt_d >= bus.WTOCNT - PREWARN_V);
`endif
    end

    assign bus.WTO      = wto_q;
    assign bus.isCNTRST = ack_q;
    assign bus.CNT      = cnt_q;
`ifdef WDT_PREWARN_EN
    assign bus.WPRE     = wpre_q;
`endif

endmodule

// File: doc/wdt_timeout_core.md
Name: wdt_timeout_core

Overview:
Watchdog counting core that sits directly downstream of the AXI watchdog register wrapper. It consumes that wrapper's enable, kick and timeout-count register outputs, counts ticks, and drives the WTO timeout interrupt toward the CPU interrupt input. It returns a one-cycle kick acknowledge so the wrapper can clear its kick register. Single clock domain; no CDC inside this block.

Parameters:
PRESCALE, 1, clk cycles per counter tick (legal range ≥1).
CNT_W, 32, width of WTOCNT and the tick counter.
PREWARN_CNT, 16, ticks before timeout at which WPRE asserts (optional feature only).

Ports:
clk  in  1  system clock.
rst  in  1  reset; synchronous, active-high.
WDEN  in  1  watchdog enable level from wrapper.
WDLIVE  in  1  kick request level. The wrapper holds it until it sees isCNTRST.
WTOCNT  in  CNT_W  timeout threshold in ticks. Compared live every tick.
WTO  out  1  timeout interrupt. Registered, level.
isCNTRST  out  1  kick acknowledge. Registered, one-cycle pulse.
CNT  out  CNT_W  current tick count. Debug/readback.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: state=IDLE, CNT=0, prescale counter=0, WTO=0, isCNTRST=0, WPRE=0.
- Kick acceptance:
  - Kick accepted when WDLIVE=1 and isCNTRST=0, in any state.
  - isCNTRST=1 on the cycle after acceptance, then returns to 0.
  - WDLIVE is ignored while isCNTRST=1, so a held level yields at most one acceptance every 2 cycles.
- Tick: the prescale counter counts 0..PRESCALE-1. A tick occurs when it equals PRESCALE-1, then it wraps to 0. It is cleared on kick acceptance and on IDLE->RUN. With PRESCALE=1, every cycle in RUN is a tick.
- IDLE:
  - CNT=0, WTO=0.
  - WDEN=1 -> RUN with CNT=0.
  - A kick in IDLE is acknowledged with no other effect.
- RUN:
  - Priority order: WDEN=0 > kick > tick.
  - WDEN=0 -> IDLE, CNT<=0, WTO stays 0.
  - Kick -> CNT<=0, prescale<=0, stay in RUN.
  - Tick with CNT>=WTOCNT -> EXPIRED, WTO<=1, CNT frozen.
  - Tick otherwise -> CNT<=CNT+1.
- Timeout latency: WTO rises (WTOCNT+1)*PRESCALE cycles after the RUN entry edge. WTOCNT=0 expires on the first tick.
- Counter range: the >= compare means lowering WTOCNT below CNT mid-run expires on the next tick. CNT never exceeds WTOCNT+0, so no wrap is possible.
- EXPIRED:
  - WTO held at 1.
  - WDEN=0 -> IDLE, WTO<=0, CNT<=0.
  - Kick -> RUN, WTO<=0, CNT<=0, acknowledge pulse.
  - WDEN=0 with a simultaneous kick: IDLE wins, and the kick is still acknowledged.
- Reset asserted mid-operation returns to reset values on that edge, regardless of state.
- No other outputs change without a state transition.

Optional Feature:
Macro WDT_PREWARN_EN.
- Defined:
  - Adds output port WPRE (1 bit, registered).
  - WPRE=1 in RUN when WTOCNT>=PREWARN_CNT and CNT>=WTOCNT-PREWARN_CNT.
  - WPRE is forced to 0 in IDLE and EXPIRED, and on the cycle after a kick.
- Undefined: no WPRE port and no compare logic. All other behaviour is identical.

Test Plan:
1. PRESCALE=1, WTOCNT=5, WDEN 0->1, no kick -> CNT counts 0..5, WTO rises exactly 6 cycles after RUN entry and stays high.
2. WTOCNT=10, kick at CNT=7 with WDLIVE held 3 cycles -> isCNTRST pulses on cycles +1 and +3, CNT returns to 0 each time, WTO never rises before 11 ticks after the last kick.
3. In EXPIRED, pulse WDLIVE -> WTO falls next cycle, isCNTRST=1 for one cycle, CNT=0, counting resumes. Then drop WDEN at CNT=3 -> IDLE, CNT=0, WTO=0.
4. PRESCALE=4, WTOCNT=2 -> WTO rises 12 cycles after enable. Lower WTOCNT to 0 at CNT=1 -> WTO at the next tick boundary.
5. Assert rst for one cycle while EXPIRED with a kick pending -> all outputs 0 after the edge, no isCNTRST pulse. WTOCNT=0 then enable -> WTO after 1 tick.
6. WDT_PREWARN_EN defined, PREWARN_CNT=3, WTOCNT=8 -> WPRE rises when CNT reaches 5, falls on kick or on expiry. Macro undefined -> build has no WPRE port, scenarios 1–5 unchanged.
